// File: rtl/intsrcarb_if.sv
// Purpose : bundles the pi1 config port, intctrl source handshake and device lines of intsrcarb.
// Ports   : slave = arbiter side (pi1 target, drives intrqst_o/devrdy_o); master = bus/peripheral side.
// Latency : none (wires only); backpressure: pi1 is always ready, intctrl stalls via intrdy_i.
interface intsrcarb_if #(
    parameter int SRCCOUNT  = 8,
    parameter int ARCHBITSZ = 32
);
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);

    logic [1:0]             pi1_op_i;
    logic [ADDRBITSZ-1:0]   pi1_addr_i;
    logic [ARCHBITSZ-1:0]   pi1_data_i;
    logic [ARCHBITSZ-1:0]   pi1_data_o;
    logic [ARCHBITSZ/8-1:0] pi1_sel_i;
    logic                   pi1_rdy_o;
    logic [ADDRBITSZ-1:0]   pi1_mapsz_o;
    logic                   intrqst_o;
    logic                   intrdy_i;
    logic [SRCCOUNT-1:0]    devrqst_i;
    logic [SRCCOUNT-1:0]    devrdy_o;

    modport slave (
        input  pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i, intrdy_i, devrqst_i,
        output pi1_data_o, pi1_rdy_o, pi1_mapsz_o, intrqst_o, devrdy_o
    );

    modport master (
        output pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i, intrdy_i, devrqst_i,
        input  pi1_data_o, pi1_rdy_o, pi1_mapsz_o, intrqst_o, devrdy_o
    );
endinterface

// File: rtl/intsrcarb.sv
// Purpose : shares one intctrl source input among SRCCOUNT edge-triggered devices (round-robin or fixed priority).
// Ports   : clk_i/rst_i (sync, active-high), bus = intsrcarb_if.slave (pi1 regs, intrqst_o/intrdy_i, devrqst_i/devrdy_o).
// Latency : edge -> PEND +1 -> intrqst_o +2; backpressure: request held until intrdy_i low, then 1-cycle devrdy_o ack.
module intsrcarb #(
    parameter int SRCCOUNT  = 8,
    parameter int ARCHBITSZ = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    intsrcarb_if.slave  bus
);
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);
    localparam int NBYTES    = ARCHBITSZ / 8;
    localparam int IDW       = (SRCCOUNT > 1) ? $clog2(SRCCOUNT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t                state_q, state_d;
    logic [SRCCOUNT-1:0]   mask_q, pend_q, pend_d, prev_q;
    logic                  en_q, fix_q, last_vld_q;
    logic [IDW-1:0]        last_id_q, win_q, rrptr_q;
    logic [ARCHBITSZ-1:0]  rdata_q;

    logic [ARCHBITSZ-1:0]  bmask, wdat, rd_val;
    logic [SRCCOUNT-1:0]   elig, clr;
    logic [IDW-1:0]        pick, start;
    logic [IDW:0]          idx_sum;
    logic                  found;
    logic                  wr_en, rd_en;
    logic [1:0]            reg_sel;
    logic                  intrqst;
    logic [SRCCOUNT-1:0]   devrdy;

    assign wr_en   = bus.pi1_op_i[0];
    assign rd_en   = bus.pi1_op_i[1];
    assign reg_sel = bus.pi1_addr_i[1:0];

    // Expand byte enables to a bit mask so writes only touch selected bytes.
    always_comb begin
        bmask = '0;
        for (int b = 0; b < NBYTES; b++) begin
            bmask[b*8 +: 8] = {8{bus.pi1_sel_i[b]}};
        end
    end
    assign wdat = bus.pi1_data_i & bmask;

    // Winner search: scan from the rr pointer (or from 0 in fixed priority) with wrap.
    always_comb begin
        elig    = en_q ? (pend_q & mask_q) : '0;
        start   = fix_q ? '0 : rrptr_q;
        found   = 1'b0;
        pick    = '0;
        idx_sum = '0;
        for (int k = 0; k < SRCCOUNT; k++) begin
            idx_sum = {1'b0, start} + (IDW+1)'(k);
            if (idx_sum >= (IDW+1)'(SRCCOUNT)) begin
                idx_sum = idx_sum - (IDW+1)'(SRCCOUNT);
            end
            if (!found && elig[idx_sum[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx_sum[IDW-1:0];
            end
        end
    end

    // Pending update: W1C and service clear lose against a same-cycle rising edge.
    always_comb begin
        clr = '0;
        if (wr_en && reg_sel == 2'd1) begin
            clr = wdat[SRCCOUNT-1:0];
        end
        if (state_q == ACK) begin
            clr[win_q] = 1'b1;
        end
        pend_d = (pend_q & ~clr) | (bus.devrqst_i & ~prev_q);
    end

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            2'd0: rd_val[SRCCOUNT-1:0] = mask_q;
            2'd1: rd_val[SRCCOUNT-1:0] = pend_q;
            2'd2: begin
                rd_val[ARCHBITSZ-1] = last_vld_q;
                rd_val[IDW-1:0]     = last_id_q;
            end
            default: rd_val[1:0] = {fix_q, en_q};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; REQ only leaves on intrdy_i low so a request is never retracted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = REQ;
            REQ:     if (!bus.intrdy_i) state_d = ACK;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        intrqst = (state_q == REQ);
        devrdy  = '1;
        if (state_q == ACK) begin
            devrdy[win_q] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q     <= '0;
            pend_q     <= '0;
            prev_q     <= '0;
            en_q       <= 1'b0;
            fix_q      <= 1'b0;
            last_vld_q <= 1'b0;
            last_id_q  <= '0;
            win_q      <= '0;
            rrptr_q    <= '0;
            rdata_q    <= '0;
        end else begin
            prev_q <= bus.devrqst_i;
            pend_q <= pend_d;
            if (wr_en && reg_sel == 2'd0) begin
                mask_q <= (mask_q & ~bmask[SRCCOUNT-1:0]) | wdat[SRCCOUNT-1:0];
            end
            if (wr_en && reg_sel == 2'd3 && bus.pi1_sel_i[0]) begin
                en_q  <= wdat[0];
                fix_q <= wdat[1];
            end
            if (state_q == IDLE && found) begin
                win_q <= pick;
            end
            if (state_q == ACK) begin
                last_vld_q <= 1'b1;
                last_id_q  <= win_q;
                rrptr_q    <= (win_q == IDW'(SRCCOUNT-1)) ? '0 : win_q + 1'b1;
            end
            // Read samples the pre-write value, which gives swap semantics for op 11.
            if (rd_en) begin
                rdata_q <= rd_val;
            end
        end
    end

    assign bus.pi1_data_o  = rdata_q;
    assign bus.pi1_rdy_o   = 1'b1;
    assign bus.pi1_mapsz_o = ADDRBITSZ'(4);
    assign bus.intrqst_o   = intrqst;
    assign bus.devrdy_o    = devrdy;

    // Upper address/data bits are intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{bus.pi1_addr_i, wdat};
endmodule

// File: tb/tb_intsrcarb.sv
module tb_intsrcarb;
    localparam int S = 8;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    intsrcarb_if #(.SRCCOUNT(S), .ARCHBITSZ(W)) bus ();
    intsrcarb #(.SRCCOUNT(S), .ARCHBITSZ(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    endtask

    // Reference model: sources waiting, one in flight, one being acknowledged.
    localparam int P_WAIT = 0, P_ASK = 1, P_ACK = 2;
    bit [7:0]  m_mask, m_pend, m_prev;
    bit        m_en, m_fix, m_lv;
    int        m_lid, m_ptr, m_win, m_phase;
    bit [31:0] m_rdata;
    int        svc_q[$];

    function automatic int pick(input bit [7:0] e);
        int s = m_fix ? 0 : m_ptr;
        for (int k = 0; k < S; k++) if (e[(s + k) % S]) return (s + k) % S;
        return -1;
    endfunction

    task automatic model_step();
        bit [31:0] bm, wd, rv;
        bit [7:0]  elig, clr, edges;
        bit        wr, rd;
        int        a;
        if (rst) begin
            m_mask = 0; m_pend = 0; m_prev = 0; m_en = 0; m_fix = 0; m_lv = 0;
            m_lid = 0; m_ptr = 0; m_win = 0; m_phase = P_WAIT; m_rdata = 0;
            return;
        end
        for (int b = 0; b < 4; b++) bm[b*8 +: 8] = bus.pi1_sel_i[b] ? 8'hFF : 8'h00;
        wd = bus.pi1_data_i & bm;
        wr = bus.pi1_op_i[0];
        rd = bus.pi1_op_i[1];
        a  = int'(bus.pi1_addr_i[1:0]);
        elig = m_en ? (m_pend & m_mask) : 8'h00;
        case (a)
            0:       rv = {24'h0, m_mask};
            1:       rv = {24'h0, m_pend};
            2:       rv = (m_lv ? 32'h8000_0000 : 32'h0) | m_lid;
            default: rv = {30'h0, m_fix, m_en};
        endcase
        edges = bus.devrqst_i & ~m_prev;
        clr   = (wr && a == 1) ? wd[7:0] : 8'h00;
        if (m_phase == P_ACK) begin
            clr[m_win] = 1'b1;
            m_lv = 1; m_lid = m_win; m_ptr = (m_win + 1) % S; m_phase = P_WAIT;
        end else if (m_phase == P_ASK) begin
            if (!bus.intrdy_i) m_phase = P_ACK;
        end else if (elig != 0) begin
            m_win = pick(elig); m_phase = P_ASK;
        end
        m_pend = (m_pend & ~clr) | edges;
        if (wr && a == 0) m_mask = (m_mask & ~bm[7:0]) | wd[7:0];
        if (wr && a == 3 && bus.pi1_sel_i[0]) begin m_en = wd[0]; m_fix = wd[1]; end
        if (rd) m_rdata = rv;
        m_prev = bus.devrqst_i;
    endtask

    task automatic tick();
        bit [7:0] exp_rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp_rdy = 8'hFF;
        if (m_phase == P_ACK) exp_rdy[m_win] = 1'b0;
        chk("intrqst", bus.intrqst_o, (m_phase == P_ASK) ? 1 : 0);
        chk("devrdy", bus.devrdy_o, exp_rdy);
        chk("rdata", bus.pi1_data_o, m_rdata);
        chk("pi1_rdy", bus.pi1_rdy_o, 1);
        chk("mapsz", bus.pi1_mapsz_o, 4);
        for (int i = 0; i < S; i++) if (!bus.devrdy_o[i]) svc_q.push_back(i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.pi1_op_i = 2'b01; bus.pi1_addr_i = 30'(a); bus.pi1_data_i = d; bus.pi1_sel_i = 4'hF;
        tick();
        bus.pi1_op_i = 2'b00;
    endtask

    task automatic rd(input int a);
        bus.pi1_op_i = 2'b10; bus.pi1_addr_i = 30'(a);
        tick();
        bus.pi1_op_i = 2'b00;
    endtask

    task automatic do_reset();
        bus.devrqst_i = '0; bus.intrdy_i = 1'b1; bus.pi1_op_i = 2'b00;
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic chk_order(input string tag, input int exp[]);
        chk({tag, "_cnt"}, svc_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(tag, (i < svc_q.size()) ? svc_q[i] : 32'hFF, exp[i]);
        svc_q.delete();
    endtask

    initial begin
        bus.pi1_op_i = 2'b00; bus.pi1_addr_i = '0; bus.pi1_data_i = '0; bus.pi1_sel_i = '0;
        bus.intrdy_i = 1'b1; bus.devrqst_i = '0;

        // single source: latency, ack pulse, clear, LAST
        do_reset();
        chk("rst_rqst", bus.intrqst_o, 0);
        chk("rst_rdy", bus.devrdy_o, 8'hFF);
        wr(3, 1); wr(0, 32'hFF);
        bus.devrqst_i = 8'h08; tick();
        chk("s1_req_early", bus.intrqst_o, 0);
        rd(1);
        chk("s1_pend", bus.pi1_data_o, 32'h08);
        chk("s1_req", bus.intrqst_o, 1);
        bus.intrdy_i = 1'b0; tick();
        chk("s1_ack", bus.devrdy_o, 8'hF7);
        bus.intrdy_i = 1'b1; bus.devrqst_i = 8'h00; tick();
        rd(1); chk("s1_pend_clr", bus.pi1_data_o, 0);
        rd(2); chk("s1_last", bus.pi1_data_o, 32'h8000_0003);
        svc_q.delete();

        // round robin order and wrap
        do_reset(); wr(3, 1); wr(0, 32'hFF);
        bus.intrdy_i = 1'b0; bus.devrqst_i = 8'h62; idle(15);
        bus.devrqst_i = 8'h00; tick();
        bus.devrqst_i = 8'h83; idle(15);
        chk_order("rr_order", '{1, 5, 6, 7, 0, 1});

        // fixed priority: in-flight request completes first
        bus.devrqst_i = 8'h00; do_reset(); wr(3, 3); wr(0, 32'hFF);
        bus.devrqst_i = 8'h40; idle(2);
        bus.devrqst_i = 8'h44; tick();
        bus.intrdy_i = 1'b0; idle(10);
        bus.devrqst_i = 8'h00; bus.intrdy_i = 1'b1; tick();
        bus.devrqst_i = 8'h44; tick();
        bus.intrdy_i = 1'b0; idle(10);
        chk_order("fix_order", '{6, 2, 2, 6});

        // masking and W1C before unmasking
        do_reset(); wr(3, 1);
        bus.devrqst_i = 8'h10; idle(4);
        chk("mask_hold", bus.intrqst_o, 0);
        rd(1); chk("mask_pend", bus.pi1_data_o, 32'h10);
        wr(0, 32'h10); chk("unmask_early", bus.intrqst_o, 0);
        tick(); chk("unmask_req", bus.intrqst_o, 1);
        do_reset(); wr(3, 1);
        bus.devrqst_i = 8'h10; tick();
        wr(1, 32'h10); wr(0, 32'h10); idle(3);
        chk("w1c_noreq", bus.intrqst_o, 0);
        svc_q.delete();

        // set wins over ACK clear and over W1C
        do_reset(); wr(3, 1); wr(0, 1);
        bus.devrqst_i = 8'h01; tick();
        bus.devrqst_i = 8'h00; tick();
        bus.intrdy_i = 1'b0; tick();
        bus.intrdy_i = 1'b1; bus.devrqst_i = 8'h01; tick();
        rd(1); chk("ack_set_wins", bus.pi1_data_o, 32'h01);
        bus.devrqst_i = 8'h00; bus.intrdy_i = 1'b0; wr(3, 0); idle(2);
        bus.intrdy_i = 1'b1; tick();
        bus.devrqst_i = 8'h01; wr(1, 32'h01);
        rd(1); chk("w1c_set_wins", bus.pi1_data_o, 32'h01);

        // swap on MASK, then reset during REQ
        do_reset(); wr(0, 32'hF0);
        bus.pi1_op_i = 2'b11; bus.pi1_addr_i = 30'd0; bus.pi1_data_i = 32'h0F; bus.pi1_sel_i = 4'hF;
        tick(); bus.pi1_op_i = 2'b00;
        chk("swap_old", bus.pi1_data_o, 32'hF0);
        rd(0); chk("swap_new", bus.pi1_data_o, 32'h0F);
        wr(3, 1); wr(0, 32'hFF); bus.devrqst_i = 8'h01; idle(2);
        chk("pre_rst_req", bus.intrqst_o, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_drop", bus.intrqst_o, 0);
        rd(0); chk("rst_mask", bus.pi1_data_o, 0);
        rd(3); chk("rst_ctrl", bus.pi1_data_o, 0);

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            bus.pi1_op_i   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            bus.pi1_addr_i = 30'($urandom);
            bus.pi1_data_i = $urandom;
            bus.pi1_sel_i  = 4'($urandom);
            bus.devrqst_i  = bus.devrqst_i ^ 8'($urandom & $urandom & $urandom);
            bus.intrdy_i   = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
